lsu_mem_ctrl: RTL

Memory-stage controller that sits directly upstream of the load-store unit and drives its read/write/byte-enable/address/data request interface. It accepts one RV32I load or store per transaction from the execute stage over a valid/ready handshake. It checks alignment and funct3 legality, generates byte enables and lane-replicated store data, and holds the LSU request until the LSU's valid returns. It then extracts and sign- or zero-extends load data and returns a registered response to writeback.

---
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_mem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Request, LSU and response signal bundle for lsu_mem_ctrl.
// slave is the controller's view; master is the surrounding pipeline/LSU view.
interface lsu_mem_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        load_i;
  logic        store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        lsu_read_o;
  logic        lsu_write_o;
  logic [3:0]  lsu_we_o;
  logic [31:0] lsu_addr_o;
  logic [31:0] lsu_data_o;
  logic [31:0] lsu_data_i;
  logic        lsu_valid_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        misaligned_o;
  logic        illegal_o;
  logic        bus_err_o;

  modport slave (
    input  req_valid_i, load_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    input  lsu_data_i, lsu_valid_i, resp_ready_i,
    output req_ready_o, lsu_read_o, lsu_write_o, lsu_we_o, lsu_addr_o, lsu_data_o,
    output resp_valid_o, resp_data_o, resp_rd_o, misaligned_o, illegal_o, bus_err_o
  );

  modport master (
    output req_valid_i, load_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    output lsu_data_i, lsu_valid_i, resp_ready_i,
    input  req_ready_o, lsu_read_o, lsu_write_o, lsu_we_o, lsu_addr_o, lsu_data_o,
    input  resp_valid_o, resp_data_o, resp_rd_o, misaligned_o, illegal_o, bus_err_o
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I memory-stage controller: validates a load/store, drives the LSU, returns a response.
// Optional LSU_TIMEOUT_EN: abort an ACCESS after TIMEOUT_CYCLES cycles with bus_err_o.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rstn_i,
  lsu_mem_ctrl_if.slave  bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        read_q, read_d, write_q, write_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        mis_q, mis_d, ill_q, ill_d;

  logic        accept, is_illegal, is_misaligned;
  logic [3:0]  st_we;
  logic [31:0] st_data, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  assign accept = bus.req_valid_i && (state_q == StIdle);

  always_comb begin
    is_illegal = (bus.load_i == bus.store_i) ||
                 (bus.load_i && (bus.funct3_i == 3'd3 || bus.funct3_i[2:1] == 2'b11)) ||
                 (bus.store_i && bus.funct3_i > 3'd2);
    // funct3[1:0]==01 covers both H and HU
    is_misaligned = ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                    ((bus.funct3_i == 3'd2) && (bus.addr_i[1:0] != 2'b00));
  end

  always_comb begin
    st_we   = 4'b1111;
    st_data = bus.wdata_i;
    case (bus.funct3_i[1:0])
      2'b00: begin
        st_we   = 4'b0001 << bus.addr_i[1:0];
        st_data = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        st_we   = 4'b0011 << bus.addr_i[1:0];
        st_data = {2{bus.wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus.lsu_data_i[7:0];
      2'd1:    ld_byte = bus.lsu_data_i[15:8];
      2'd2:    ld_byte = bus.lsu_data_i[23:16];
      default: ld_byte = bus.lsu_data_i[31:24];
    endcase
    ld_half = lane_q[1] ? bus.lsu_data_i[31:16] : bus.lsu_data_i[15:0];
    case (funct3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.lsu_data_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    mis_d        = mis_q;
    ill_d        = ill_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = bus_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = bus.funct3_i;
          lane_d   = bus.addr_i[1:0];
          rd_d     = bus.rd_i;
          if (is_illegal) begin
            ill_d        = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else if (is_misaligned) begin
            mis_d        = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else begin
            read_d  = bus.load_i;
            write_d = bus.store_i;
            addr_d  = {bus.addr_i[31:2], 2'b00};
            we_d    = bus.store_i ? st_we : 4'b0000;
            data_d  = bus.store_i ? st_data : 32'd0;
            state_d = StAccess;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (bus.lsu_valid_i) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          we_d         = 4'b0000;
          resp_data_d  = read_q ? ld_ext : 32'd0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntMax) begin
            read_d       = 1'b0;
            write_d      = 1'b0;
            we_d         = 4'b0000;
            bus_err_d    = 1'b1;
            resp_data_d  = 32'd0;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end
        end
`endif
      end
      StResp: begin
        if (bus.resp_ready_i) begin
          resp_valid_d = 1'b0;
          resp_data_d  = 32'd0;
          mis_d        = 1'b0;
          ill_d        = 1'b0;
`ifdef LSU_TIMEOUT_EN
          bus_err_d    = 1'b0;
`endif
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      we_q         <= 4'b0000;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      rd_q         <= 5'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mis_q        <= mis_d;
      ill_q        <= ill_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus.bus_err_o = bus_err_q;
`else
  assign bus.bus_err_o = 1'b0;
`endif

  assign bus.req_ready_o  = (state_q == StIdle);
  assign bus.lsu_read_o   = read_q;
  assign bus.lsu_write_o  = write_q;
  assign bus.lsu_we_o     = we_q;
  assign bus.lsu_addr_o   = addr_q;
  assign bus.lsu_data_o   = data_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_rd_o    = rd_q;
  assign bus.misaligned_o = mis_q;
  assign bus.illegal_o    = ill_q;

endmodule
